ie_muldiv_ctrl: RTL and testbench
=================================

# ie_muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide instructions, sitting beside the IE stage ALU. It accepts an M-extension operation from the ID/EX boundary, iterates one bit per cycle over a shift-add or restoring-divide datapath, and holds the pipeline with `stall` until the result is ready. The block also handles divide-by-zero and signed overflow in a single cycle, and supports pipeline flush.

## Interface
- `XLEN`, default 32: operand and result width.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  M-op present in EX; sampled only in IDLE
- `funct3`  in  3  RV32M op select (MUL..REMU)
- `r1`  in  XLEN  rs1 operand (multiplicand / dividend)
- `r2`  in  XLEN  rs2 operand (multiplier / divisor)
- `flush`  in  1  kill the in-flight op (branch taken / trap)
- `busy`  out  1  state != IDLE
- `stall`  out  1  freeze IF/ID/EX registers
- `done`  out  1  one-cycle pulse; `MResult` valid
- `MResult`  out  XLEN  result; holds its value until the next `done`

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE → RUN** on `start`:
  - latch `funct3`;
  - latch the operand magnitudes (signed ops take abs value; MULHSU treats only r1 as signed);
  - latch the result sign;
  - load `count = XLEN`.
- **IDLE → DONE** (fast path) on `start` with a special case; the result is written directly:
  - DIV/DIVU with r2 == 0: quotient = all ones.
  - REM/REMU with r2 == 0: remainder = r1.
  - DIV with r1 == 0x80000000 and r2 == 0xFFFFFFFF: quotient = 0x80000000.
  - REM with the same operands: remainder = 0.
- **RUN** performs one iteration per cycle and decrements `count`. It moves to DONE after the iteration where `count` reaches 1:
  - Multiply: 2·XLEN-bit shift-add accumulator.
  - Divide: restoring; remainder and quotient shift one bit per cycle.
- **DONE** applies the final steps, then moves to IDLE unconditionally:
  - apply the sign correction (two's-complement negate);
  - select the output: low product for MUL, high product for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU;
  - register the value into `MResult`;
  - assert `done`.
- Remainder sign follows the dividend. Quotient sign is the XOR of the operand signs.
- `start` while `busy` is ignored.
- `flush`:
  - From any state, the next state is IDLE.
  - `done` is not asserted, and `MResult` is unchanged.
  - `flush` has priority over `start` in the same cycle.
- Reset (`rst_n` == 0 at a clock edge, including mid-operation):
  - state = IDLE, `count` = 0, `MResult` = 0, `done` = 0;
  - `busy` = 0, `stall` = 0, internal accumulators = 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- Normal path:
  - RUN occupies cycles 1..XLEN;
  - DONE is cycle XLEN+1 (33 for XLEN=32);
  - `done` is high only in DONE.
- Fast path: DONE in cycle 1, and `done` is high in cycle 1.
- `stall` is combinational: (IDLE & `start` & !`flush`) | RUN.
  - It is low in DONE, so the pipeline advances at the end of the DONE cycle and captures `MResult`.
- `busy` is registered-state based: high in RUN and DONE.
- The next `start` can be accepted in the cycle after DONE. There is no back-to-back acceptance in DONE.

## Structure
- Package `m_ext_pkg` holds the shared definitions:
  - `funct3` constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111;
  - the FSM state enum (IDLE, RUN, DONE);
  - `XLEN` default.
- Sub-module `muldiv_shift_core` holds the iterative datapath:
  - accumulator and shift registers;
  - one-step add/subtract;
  - `load` and `step` inputs.
- The top level owns the FSM, the counter, sign handling, the fast-path detect and the `MResult` register.

## Test plan
- MUL r1=7, r2=6:
  - `stall` high in cycles 0..32;
  - `done` pulse in cycle 33;
  - `MResult` = 0x0000002A.
- MULH r1=r2=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU → 0xFFFFFFFF.
- DIV r1=0xFFFFFFF9 (-7), r2=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 0x0000000E.
- DIVU r1=0x64, r2=0 → 0xFFFFFFFF with `done` in cycle 1. REMU with the same operands → 0x00000064.
- DIV r1=0x80000000, r2=0xFFFFFFFF → 0x80000000 in cycle 1. REM with the same operands → 0x00000000.
- `flush` asserted in cycle 10 of a DIV:
  - IDLE in cycle 11, with `busy` and `stall` low;
  - no `done`, and `MResult` keeps its prior value.
- `rst_n` low in cycle 20 of a MUL: all outputs 0 at the next edge.

Source files
------------

// File: rtl/m_ext_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 encodings, FSM state type and default operand width.
package m_ext_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_shift_core.sv
// Iterative unsigned datapath: one shift-add multiply or restoring-divide bit per step.
// The 2*XLEN accumulator holds {product} for multiply and {remainder, quotient} for divide.
module muldiv_shift_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   b_reg;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        acc_next  = acc_reg;
        if (load) begin
            acc_next = {{XLEN{1'b0}}, a};
        end else if (step) begin
            if (!is_div) begin
                acc_next = {mul_sum, acc_reg[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
                // Trial subtraction fits: keep the difference and shift in a 1
                acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            b_reg   <= '0;
        end else begin
            acc_reg <= acc_next;
            if (load) begin
                b_reg <= b;
            end
        end
    end

    assign hi = acc_reg[2*XLEN-1:XLEN];
    assign lo = acc_reg[XLEN-1:0];

endmodule

// File: rtl/ie_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the IE ALU: FSM, iteration counter,
// sign handling, single-cycle special cases and the result register.
module ie_muldiv_ctrl
    import m_ext_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] MResult
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg;
    logic [2:0]        f3_reg;
    logic              neg_reg;
    logic              fast_reg;
    logic [XLEN-1:0]   fast_res_reg;
    logic [XLEN-1:0]   mresult_reg;

    logic              signed1, signed2, s1, s2, neg;
    logic              div0, ovf, is_fast, take;
    logic              core_load, core_step;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [XLEN-1:0]   core_hi, core_lo, quot_c, rem_c, final_res;
    logic [2*XLEN-1:0] prod, prod_c;

    // Operand decode for the op being offered in IDLE
    always_comb begin
        signed1  = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        signed2  = funct3 inside {F3_MULH, F3_DIV, F3_REM};
        s1       = signed1 & r1[XLEN-1];
        s2       = signed2 & r2[XLEN-1];
        mag1     = s1 ? -r1 : r1;
        mag2     = s2 ? -r2 : r2;
        // Remainder takes the dividend's sign; everything else the XOR of both
        neg      = (funct3 == F3_REM) ? s1 : (s1 ^ s2);
        div0     = funct3[2] && (r2 == '0);
        ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (r1 == MIN_NEG) && (r2 == '1);
        is_fast  = div0 || ovf;
        fast_res = div0 ? (funct3[1] ? r1 : '1) : (funct3[1] ? '0 : MIN_NEG);
        take     = (state_reg == IDLE) && start && !flush;
    end

    always_comb begin
        state_next = state_reg;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = is_fast ? DONE : RUN;
                    core_load  = !is_fast;
                end
            end
            RUN: begin
                core_step = 1'b1;
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            core_load  = 1'b0;
            core_step  = 1'b0;
        end
    end

    muldiv_shift_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .is_div (f3_reg[2]),
        .a      (mag1),
        .b      (mag2),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // Final sign correction and result select, evaluated while in DONE
    always_comb begin
        prod   = {core_hi, core_lo};
        prod_c = neg_reg ? -prod : prod;
        quot_c = neg_reg ? -core_lo : core_lo;
        rem_c  = neg_reg ? -core_hi : core_hi;
        case (f3_reg)
            F3_MUL:                        final_res = prod_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_c[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = quot_c;
            default:                       final_res = rem_c;
        endcase
        if (fast_reg) begin
            final_res = fast_res_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            f3_reg       <= '0;
            neg_reg      <= 1'b0;
            fast_reg     <= 1'b0;
            fast_res_reg <= '0;
            mresult_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                f3_reg       <= funct3;
                neg_reg      <= neg;
                fast_reg     <= is_fast;
                fast_res_reg <= fast_res;
                count_reg    <= CW'(XLEN);
            end else if (core_step && (count_reg != '0)) begin
                count_reg <= count_reg - CW'(1);
            end
            if (done) begin
                mresult_reg <= final_res;
            end
        end
    end

    // A flush during DONE suppresses the pulse and leaves the held result alone
    assign done    = (state_reg == DONE) && !flush;
    assign busy    = (state_reg != IDLE);
    assign stall   = take || (state_reg == RUN);
    assign MResult = done ? final_res : mresult_reg;

endmodule

// File: tb/tb_ie_muldiv_ctrl.sv
// Self-checking bench for ie_muldiv_ctrl: directed RV32M vectors, a cycle-level
// reference model checked every cycle, plus flush and mid-operation reset.
module tb_ie_muldiv_ctrl;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] r1, r2;
    logic        busy, stall, done;
    logic [31:0] MResult;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ie_muldiv_ctrl #(
        .XLEN (XLEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct3  (funct3),
        .r1      (r1),
        .r2      (r2),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .MResult (MResult)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result computed with wide arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] qa, qb, qs;
        logic [31:0]        res;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        res = '0;
        case (f)
            3'b000: begin up = ua * ub; res = up[31:0]; end
            3'b001: begin p = sa * sb; res = p[63:32]; end
            3'b010: begin p = sa * $signed(ub); res = p[63:32]; end
            3'b011: begin up = ua * ub; res = up[63:32]; end
            3'b100: begin
                if (b == 0) res = '1;
                else if (a == MIN_NEG && b == 32'hFFFF_FFFF) res = MIN_NEG;
                else begin qs = qa / qb; res = qs; end
            end
            3'b101: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) res = a;
                else if (a == MIN_NEG && b == 32'hFFFF_FFFF) res = '0;
                else begin qs = qa % qb; res = qs; end
            end
            default: res = (b == 0) ? a : a % b;
        endcase
        return res;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    endfunction

    // Reference model: cycles left until the op has finished its DONE cycle
    int          remaining = 0;
    logic [31:0] pending   = '0;
    logic [31:0] held      = '0;
    bit          exp_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            remaining = 0;
            held      = '0;
        end else if (flush) begin
            remaining = 0;
        end else if (remaining == 0) begin
            if (start) begin
                pending   = ref_op(funct3, r1, r2);
                remaining = is_special(funct3, r1, r2) ? 1 : XLEN + 1;
            end
        end else begin
            if (remaining == 1) held = pending;
            remaining--;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_done = (remaining == 1) && !flush;
            check("busy", 32'(busy), 32'(remaining > 0));
            check("stall", 32'(stall), 32'(((remaining == 0) && start && !flush) || (remaining > 1)));
            check("done", 32'(done), 32'(exp_done));
            check("mresult", MResult, exp_done ? pending : held);
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit poke);
        int cyc;
        bit seen;
        check("model_pin", ref_op(f, a, b), exp);
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; r1 = a; r2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc <= 60) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("latency", 32'(cyc), 32'(exp_lat));
                check("result", MResult, exp);
            end else begin
                @(posedge clk); #1;
                cyc++;
                start = poke && (cyc == 5);
            end
        end
        if (!seen) check("done_timeout", 32'(cyc), 32'(exp_lat));
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; r1 = '0; r2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_mresult", MResult, 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op(3'b000, 32'd7,          32'd6,          32'h0000_002A, 33, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, 1'b0);
        run_op(3'b101, 32'd100,        32'd7,          32'h0000_000E, 33, 1'b1);
        run_op(3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33, 1'b0);
        run_op(3'b110, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 33, 1'b0);
        run_op(3'b101, 32'h0000_0064,  32'd0,          32'hFFFF_FFFF, 1,  1'b0);
        run_op(3'b111, 32'h0000_0064,  32'd0,          32'h0000_0064, 1,  1'b0);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  1'b0);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1,  1'b0);
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33, 1'b0);

        // Flush in cycle 10 of a DIV
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; r1 = 32'd100; r2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_mresult", MResult, 32'h4000_0000);
        n = 0;
        repeat (40) begin @(negedge clk); if (done) n++; end
        check("flush_no_done", 32'(n), 32'd0);

        // Reset in cycle 20 of a MUL
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; r1 = 32'd7; r2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_mresult", MResult, 32'd0);
        n = 0;
        repeat (40) begin @(negedge clk); if (done) n++; end
        check("midrst_no_done", 32'(n), 32'd0);

        run_op(3'b000, 32'd7, 32'd6, 32'h0000_002A, 33, 1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
